pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 core (F, D, E, M, W).
- Watches decode/execute/memory/writeback stage fields each cycle and drives the stall/bubble controls of pc_reg, if_id, id_ex and the downstream ex_mem/mem_wb registers.
- Also gates the condition-code update.
- Sequential part: a ret-wait counter FSM and a sticky halt state entered on a non-AOK writeback status.

Parameters:
- RET_BUBBLES, 3, total cycles F is held and D bubbled for one ret (range 1..7).
- REG_W, 4, register-id width; RNONE = all ones.
- ICODE_W, 4, icode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- d_icode  in  ICODE_W  icode in decode stage.
- d_srcA  in  REG_W  decode source A id.
- d_srcB  in  REG_W  decode source B id.
- e_icode  in  ICODE_W  icode in execute stage.
- e_dstM  in  REG_W  execute-stage memory destination id.
- e_cnd  in  1  jXX condition result in execute (1 = taken).
- m_stat  in  3  memory-stage status.
- w_stat  in  3  writeback-stage status.
- f_stall  out  1  hold pc_reg.
- d_stall  out  1  hold if_id.
- d_bubble  out  1  load nop into if_id.
- e_bubble  out  1  load nop into id_ex.
- m_bubble  out  1  load nop into ex_mem.
- w_stall  out  1  hold mem_wb.
- set_cc  out  1  condition codes may update this cycle.
- halted  out  1  core stopped; sticky until reset.

Behaviour:
- Constants: icodes HALT=0, NOP=1, RRMOVL=2, IRMOVL=3, RMMOVL=4, MRMOVL=5, OPL=6, JXX=7, CALL=8, RET=9, PUSHL=A, POPL=B. Status codes AOK=1, HLT=2, ADR=3, INS=4.
- States: RUN, RETW (counter cnt, 3 bits), HALT.
- While rst=0, asynchronously:
  - state=RUN, cnt=0, halted=0.
  - Outputs forced to: d_bubble=1, e_bubble=1, m_bubble=1; f_stall=0, d_stall=0, w_stall=0, set_cc=0.
- Conditions, evaluated combinationally from current inputs and state:
  - LU (load-use): e_icode is MRMOVL or POPL, e_dstM != RNONE, and e_dstM equals d_srcA or d_srcB.
  - MP (mispredict; branches are predicted taken): e_icode=JXX and e_cnd=0.
  - RD (ret decoded): state=RUN and d_icode=RET and neither LU nor MP.
  - EX (exception): m_stat != AOK or w_stat != AOK.
- RUN state outputs:
  - f_stall = LU or RD.
  - d_stall = LU.
  - d_bubble = MP or RD.
  - e_bubble = LU or MP.
  - m_bubble = EX.
  - w_stall = 0.
- RETW state outputs: f_stall=1, d_bubble=1. e_bubble is driven from LU/MP as in RUN (in practice 0, since D is bubbled).
- Priority:
  - LU over RD: the ret stays in D, no bubble, FSM does not advance.
  - MP over RD: the ret is on the wrong path, D is bubbled, RETW is not entered.
  - LU and MP are mutually exclusive by icode.
- Transitions:
  - RUN -> RETW on RD, with cnt loaded to RET_BUBBLES-2. If RET_BUBBLES=1, stay in RUN.
  - In RETW, cnt decrements each cycle; at cnt=0 go to RUN.
  - Any state -> HALT when w_stat != AOK, at the clock edge. This transition beats all others.
- Total ret hold is exactly RET_BUBBLES cycles, counting the decode cycle.
- HALT state (sticky, exit only via rst):
  - halted=1.
  - f_stall=1, d_stall=1, e_bubble=1, m_bubble=1, w_stall=1, d_bubble=0.
- set_cc = (e_icode=OPL) and not EX and state!=HALT.
- No output depends on next-state values; all outputs are combinational from the current state and inputs.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds ports stall_cnt out 32 and bubble_cnt out 32.
  - stall_cnt increments on cycles with f_stall=1 and state!=HALT.
  - bubble_cnt increments on cycles where d_bubble or e_bubble is set because of MP or LU.
  - Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Icode constants, status codes, RNONE and the stat width go in the shared defines.v package, next to the existing `BYTE/`WORD macros.
- Sub-module pipe_hazard_det: purely combinational, computes LU, MP and EX. pipe_ctrl holds the FSM, the counter and the output mux.

Test Plan:
- Reset: rst=0 mid-RETW with cnt=1 -> d_bubble=e_bubble=m_bubble=1, set_cc=0, halted=0. After rst=1 with idle inputs, all outputs are 0.
- Load-use: e_icode=5, e_dstM=3, d_srcB=3 -> f_stall=d_stall=e_bubble=1 for that cycle only. With e_dstM=F, no stall.
- Mispredict: e_icode=7, e_cnd=0, d_icode=9 -> d_bubble=e_bubble=1, f_stall=0, and the FSM stays in RUN next cycle.
- Ret: d_icode=9 for one cycle, then nop -> f_stall=d_bubble=1 for exactly 3 cycles, 0 on the 4th. Repeat with RET_BUBBLES=5 -> 5 cycles.
- Load-use plus ret: e_icode=B, e_dstM=4, d_icode=9, d_srcA=4 -> cycle 1 stall only (d_bubble=0). Then 3 ret cycles follow.
- Halt: w_stat=2 while e_icode=6 -> cycle 1 set_cc=0, m_bubble=1. From cycle 2, halted=1, all holds asserted. halted persists until rst=0; with PERF, stall_cnt is frozen while halted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86 definitions: byte/word widths, icodes, status codes, RNONE,
// and the pipeline-control FSM state type.
package pipe_ctrl_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   localparam int unsigned ICODE_DEF_W = 4;
   localparam logic [ICODE_DEF_W-1:0] I_HALT   = 4'h0;
   localparam logic [ICODE_DEF_W-1:0] I_NOP    = 4'h1;
   localparam logic [ICODE_DEF_W-1:0] I_RRMOVL = 4'h2;
   localparam logic [ICODE_DEF_W-1:0] I_IRMOVL = 4'h3;
   localparam logic [ICODE_DEF_W-1:0] I_RMMOVL = 4'h4;
   localparam logic [ICODE_DEF_W-1:0] I_MRMOVL = 4'h5;
   localparam logic [ICODE_DEF_W-1:0] I_OPL    = 4'h6;
   localparam logic [ICODE_DEF_W-1:0] I_JXX    = 4'h7;
   localparam logic [ICODE_DEF_W-1:0] I_CALL   = 4'h8;
   localparam logic [ICODE_DEF_W-1:0] I_RET    = 4'h9;
   localparam logic [ICODE_DEF_W-1:0] I_PUSHL  = 4'hA;
   localparam logic [ICODE_DEF_W-1:0] I_POPL   = 4'hB;

   localparam int unsigned STAT_W = 3;
   localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
   localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
   localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
   localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

   // RNONE is all ones at the default register-id width.
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      RETW = 2'd1,
      HALT = 2'd2
   } ctrlState_t;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational hazard detection: load-use, branch mispredict and
// pipeline exception (non-AOK status in M or W).
module pipe_hazard_det
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W   = 4,
   parameter int unsigned ICODE_W = 4
) (
   input  logic [ICODE_W-1:0] eIcode,
   input  logic [REG_W-1:0]   dSrcA,
   input  logic [REG_W-1:0]   dSrcB,
   input  logic [REG_W-1:0]   eDstM,
   input  logic               eCnd,
   input  logic [STAT_W-1:0]  mStat,
   input  logic [STAT_W-1:0]  wStat,
   output logic               loadUse,
   output logic               mispredict,
   output logic               exception
);

   logic isLoad;

   assign isLoad     = (eIcode == ICODE_W'(I_MRMOVL)) || (eIcode == ICODE_W'(I_POPL));
   assign loadUse    = isLoad && (eDstM != '1) && ((eDstM == dSrcA) || (eDstM == dSrcB));
   assign mispredict = (eIcode == ICODE_W'(I_JXX)) && !eCnd;
   assign exception  = (mStat != STAT_AOK) || (wStat != STAT_AOK);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: stall/bubble generation, ret-wait FSM, sticky halt.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/bubble event counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned RET_BUBBLES = 3,
   parameter int unsigned REG_W       = 4,
   parameter int unsigned ICODE_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ICODE_W-1:0] d_icode,
   input  logic [REG_W-1:0]   d_srcA,
   input  logic [REG_W-1:0]   d_srcB,
   input  logic [ICODE_W-1:0] e_icode,
   input  logic [REG_W-1:0]   e_dstM,
   input  logic               e_cnd,
   input  logic [STAT_W-1:0]  m_stat,
   input  logic [STAT_W-1:0]  w_stat,
   output logic               f_stall,
   output logic               d_stall,
   output logic               d_bubble,
   output logic               e_bubble,
   output logic               m_bubble,
   output logic               w_stall,
   output logic               set_cc,
`ifdef PIPE_CTRL_PERF_EN
   output logic               halted,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        bubble_cnt
`else
   output logic               halted
`endif
);

   ctrlState_t state, stateNext;
   logic [2:0] cnt, cntNext;
   logic       loadUse, mispredict, exception, retDecode;

   pipe_hazard_det #(
      .REG_W   (REG_W),
      .ICODE_W (ICODE_W)
   ) uHazard (
      .eIcode     (e_icode),
      .dSrcA      (d_srcA),
      .dSrcB      (d_srcB),
      .eDstM      (e_dstM),
      .eCnd       (e_cnd),
      .mStat      (m_stat),
      .wStat      (w_stat),
      .loadUse    (loadUse),
      .mispredict (mispredict),
      .exception  (exception)
   );

   // A ret held by load-use or squashed by a mispredict must not start the wait.
   assign retDecode = (state == RUN) && (d_icode == ICODE_W'(I_RET)) && !loadUse && !mispredict;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      if (w_stat != STAT_AOK) begin
         stateNext = HALT;
      end else begin
         case (state)
            RUN: begin
               if (retDecode && (RET_BUBBLES > 1)) begin
                  stateNext = RETW;
                  cntNext   = 3'(RET_BUBBLES - 2);
               end
            end
            RETW: begin
               if (cnt == '0) stateNext = RUN;
               else           cntNext   = cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      d_bubble = 1'b0;
      e_bubble = 1'b0;
      m_bubble = 1'b0;
      w_stall  = 1'b0;
      set_cc   = 1'b0;
      halted   = 1'b0;
      if (!rst) begin
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
      end else begin
         case (state)
            HALT: begin
               f_stall  = 1'b1;
               d_stall  = 1'b1;
               e_bubble = 1'b1;
               m_bubble = 1'b1;
               w_stall  = 1'b1;
               halted   = 1'b1;
            end
            RETW: begin
               f_stall  = 1'b1;
               d_bubble = 1'b1;
               e_bubble = loadUse || mispredict;
               m_bubble = exception;
            end
            default: begin
               f_stall  = loadUse || retDecode;
               d_stall  = loadUse;
               d_bubble = mispredict || retDecode;
               e_bubble = loadUse || mispredict;
               m_bubble = exception;
            end
         endcase
         set_cc = (e_icode == ICODE_W'(I_OPL)) && !exception && (state != HALT);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (state != HALT) begin
         if (f_stall && (stall_cnt != '1))                   stall_cnt  <= stall_cnt + 32'd1;
         if ((loadUse || mispredict) && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
